// File: rtl/peri_seq_ctrl.sv
// Memory-mapped sequencer for eFlash row access: precharge, wordline, two ADC phases,
// capture and discharge, with a readable result buffer and status register.
module peri_seq_ctrl #(
    parameter int          ROWS   = 128,
    parameter int          COLS   = 128,
    parameter int          OUT_W  = 1024,
    parameter logic [31:0] BASE   = 32'h4000_0000,
    parameter int          T_PRE  = 4,
    parameter int          T_WL   = 4,
    parameter int          T_ADC  = 8,
    parameter int          T_DISC = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      ADDRESS_I,
    input  logic [31:0]      DATA_I,
    input  logic             WR_EN_I,
    input  logic             RD_EN_I,
    output logic [31:0]      DATA_O,
    input  logic [OUT_W-1:0] EFLASH_OUTPUT_1_I,
    output logic [1:0]       MODE_O,
    output logic [ROWS-1:0]  WL_SEL_O,
    output logic [ROWS-1:0]  VPASS_EN_O,
    output logic [COLS-1:0]  PRECB_O,
    output logic [COLS-1:0]  DISC_O,
    output logic             ADC_EN1_O,
    output logic             ADC_EN2_O
);

    localparam int NW = OUT_W / 32;
    localparam logic [1:0] MODE_READ = 2'd1;
    localparam logic [1:0] MODE_MAC  = 2'd2;
    localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRECH, S_WL, S_ADC1, S_ADC2, S_CAPT, S_DISC
    } state_t;

    state_t            r_state, w_state_n;
    logic [15:0]       r_cnt, w_cnt_n;
    logic [1:0]        r_mode;
    logic [7:0]        r_row;
    logic              r_done, r_err;
    logic [OUT_W-1:0]  r_buf;
    logic [31:0]       r_data;
    logic [1:0]        r_mode_o;
    logic [ROWS-1:0]   r_wl, r_vpass;
    logic [COLS-1:0]   r_precb, r_disc;
    logic              r_adc1, r_adc2;

    logic              w_hit, w_cmd_wr, w_legal, w_start, w_err_clr, w_busy, w_wl_on;
    logic [7:0]        w_off;
    logic [1:0]        w_mode_n;
    logic [7:0]        w_row_n;
    logic [ROWS-1:0]   w_onehot;
    logic [5:0]        w_rd_idx;
    logic              w_res_hit;
    logic [31:0]       w_rd_data;
    logic              w_unused;

    assign w_unused  = ^{DATA_I[31:16], DATA_I[7:3]};
    assign w_hit     = (ADDRESS_I[31:8] == BASE[31:8]);
    assign w_off     = ADDRESS_I[7:0];
    assign w_cmd_wr  = WR_EN_I && w_hit && (w_off == 8'h00);
    assign w_legal   = ((DATA_I[1:0] == MODE_READ) || (DATA_I[1:0] == MODE_MAC)) &&
                       ({1'b0, DATA_I[15:8]} < 9'(ROWS));
    assign w_start   = w_cmd_wr && (r_state == S_IDLE) && w_legal;
    assign w_err_clr = WR_EN_I && w_hit && (w_off == 8'h04) && DATA_I[2];
    assign w_busy    = (r_state != S_IDLE);
    assign w_mode_n  = w_start ? DATA_I[1:0] : r_mode;
    assign w_row_n   = w_start ? DATA_I[15:8] : r_row;

    // One down-counter shared by all states; it is reloaded with (hold - 1) on entry.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = (r_cnt != 16'd0) ? r_cnt - 16'd1 : 16'd0;
        unique case (r_state)
            S_IDLE:  if (w_start) begin w_state_n = S_PRECH; w_cnt_n = 16'(T_PRE - 1); end
            S_PRECH: if (r_cnt == 16'd0) begin w_state_n = S_WL; w_cnt_n = 16'(T_WL - 1); end
            S_WL:    if (r_cnt == 16'd0) begin w_state_n = S_ADC1; w_cnt_n = 16'(T_ADC - 1); end
            S_ADC1:  if (r_cnt == 16'd0) begin w_state_n = S_ADC2; w_cnt_n = 16'(T_ADC - 1); end
            S_ADC2:  if (r_cnt == 16'd0) begin w_state_n = S_CAPT; w_cnt_n = 16'd0; end
            S_CAPT:  begin w_state_n = S_DISC; w_cnt_n = 16'(T_DISC - 1); end
            S_DISC:  if (r_cnt == 16'd0) begin w_state_n = S_IDLE; w_cnt_n = 16'd0; end
            default: begin w_state_n = S_IDLE; w_cnt_n = 16'd0; end
        endcase
    end

    assign w_onehot = ROW_ONE << w_row_n;
    assign w_wl_on  = (w_state_n == S_WL) || (w_state_n == S_ADC1) ||
                      (w_state_n == S_ADC2) || (w_state_n == S_CAPT);

    // Result words start at offset 0x10; anything else that is not STATUS reads as zero.
    assign w_rd_idx  = w_off[7:2] - 6'd4;
    assign w_res_hit = (w_off[1:0] == 2'b00) && (w_off >= 8'h10) && (int'(w_rd_idx) < NW);

    always_comb begin
        w_rd_data = 32'd0;
        if (w_off == 8'h04)
            w_rd_data = {29'd0, r_err, r_done, w_busy};
        else if (w_res_hit)
            w_rd_data = 32'(r_buf >> {w_rd_idx, 5'b00000});
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= 16'd0;
            r_mode   <= 2'd0;
            r_row    <= 8'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_buf    <= '0;
            r_data   <= 32'd0;
            r_mode_o <= 2'd0;
            r_wl     <= '0;
            r_vpass  <= '0;
            r_precb  <= '1;
            r_disc   <= '0;
            r_adc1   <= 1'b0;
            r_adc2   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            if (w_start) begin
                r_mode <= DATA_I[1:0];
                r_row  <= DATA_I[15:8];
                r_done <= 1'b0;
            end
            if ((r_state == S_DISC) && (w_state_n == S_IDLE))
                r_done <= 1'b1;
            if (w_cmd_wr && !w_start)
                r_err <= 1'b1;
            else if (w_err_clr)
                r_err <= 1'b0;
            if (r_state == S_CAPT)
                r_buf <= EFLASH_OUTPUT_1_I;
            if (RD_EN_I)
                r_data <= w_hit ? w_rd_data : 32'd0;
            // Array controls are registered from the next state so they align with it.
            r_mode_o <= (w_state_n != S_IDLE) ? w_mode_n : 2'd0;
            r_wl     <= w_wl_on ? w_onehot : '0;
            r_vpass  <= (w_wl_on && (w_mode_n == MODE_READ)) ? ~w_onehot : '0;
            r_precb  <= (w_state_n == S_PRECH) ? '0 : '1;
            r_disc   <= (w_state_n == S_DISC) ? '1 : '0;
            r_adc1   <= (w_state_n == S_ADC1);
            r_adc2   <= (w_state_n == S_ADC2);
        end
    end

    assign DATA_O     = r_data;
    assign MODE_O     = r_mode_o;
    assign WL_SEL_O   = r_wl;
    assign VPASS_EN_O = r_vpass;
    assign PRECB_O    = r_precb;
    assign DISC_O     = r_disc;
    assign ADC_EN1_O  = r_adc1;
    assign ADC_EN2_O  = r_adc2;

endmodule

// File: tb/tb_peri_seq_ctrl.sv
// Directed bench for peri_seq_ctrl: default instance plus a small ROWS=16, T_ADC=1 instance.
module tb_peri_seq_ctrl;

    localparam logic [31:0] A_CMD  = 32'h4000_0000;
    localparam logic [31:0] A_STAT = 32'h4000_0004;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, wr, rd;
    logic [31:0]   addr, wdata, dout;
    logic [1023:0] efl;
    logic [1:0]    mode;
    logic [127:0]  wl, vpass, precb, disc;
    logic          adc1, adc2;

    logic          rst2, wr2, rd2;
    logic [31:0]   addr2, wdata2, dout2;
    logic [63:0]   efl2;
    logic [1:0]    mode2;
    logic [15:0]   wl2, vpass2;
    logic [127:0]  precb2, disc2;
    logic          adc1_2, adc2_2;

    int checks = 0;
    int errors = 0;

    peri_seq_ctrl dut (
        .CLK(clk), .RST(rst), .ADDRESS_I(addr), .DATA_I(wdata), .WR_EN_I(wr), .RD_EN_I(rd),
        .DATA_O(dout), .EFLASH_OUTPUT_1_I(efl), .MODE_O(mode), .WL_SEL_O(wl),
        .VPASS_EN_O(vpass), .PRECB_O(precb), .DISC_O(disc), .ADC_EN1_O(adc1), .ADC_EN2_O(adc2)
    );

    peri_seq_ctrl #(.ROWS(16), .OUT_W(64), .T_ADC(1)) dut2 (
        .CLK(clk), .RST(rst2), .ADDRESS_I(addr2), .DATA_I(wdata2), .WR_EN_I(wr2), .RD_EN_I(rd2),
        .DATA_O(dout2), .EFLASH_OUTPUT_1_I(efl2), .MODE_O(mode2), .WL_SEL_O(wl2),
        .VPASS_EN_O(vpass2), .PRECB_O(precb2), .DISC_O(disc2), .ADC_EN1_O(adc1_2), .ADC_EN2_O(adc2_2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd1(input logic [31:0] a);
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic wr_2(input logic [31:0] a, input logic [31:0] d);
        addr2 = a; wdata2 = d; wr2 = 1'b1;
        tick();
        wr2 = 1'b0;
    endtask

    task automatic rd_2(input logic [31:0] a);
        addr2 = a; rd2 = 1'b1;
        tick();
        rd2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1;
        tick(); tick();
        rst = 1'b0; rst2 = 1'b0;
        checks++;
        if ({precb, disc} !== {{128{1'b1}}, 128'd0}) begin
            errors++; $display("FAIL reset_precb_disc got %h %h exp all-ones zero", precb, disc);
        end
        checks++;
        if ({wl, vpass} !== 256'd0) begin
            errors++; $display("FAIL reset_wl_vpass got %h %h exp 0", wl, vpass);
        end
        checks++;
        if ({adc1, adc2, mode, dout} !== 36'd0) begin
            errors++; $display("FAIL reset_ctrl got %b %b %h %h exp 0", adc1, adc2, mode, dout);
        end
        rd1(A_STAT);
        checks++;
        if (dout !== 32'd0) begin
            errors++; $display("FAIL reset_status got %h exp 0", dout);
        end
    endtask

    task automatic test_seq_timing();
        logic [127:0] e_precb, e_disc, e_wl, e_vpass;
        logic [3:0]   e_ctl;
        efl = '0;
        wr1(A_CMD, 32'h0000_0501);
        for (int c = 1; c <= 29; c++) begin
            if (c <= 28) begin
                e_precb = (c >= 1 && c <= 4) ? 128'd0 : {128{1'b1}};
                e_disc  = (c >= 26 && c <= 27) ? {128{1'b1}} : 128'd0;
                e_wl    = (c >= 5 && c <= 25) ? (128'd1 << 5) : 128'd0;
                e_vpass = (c >= 5 && c <= 25) ? ~(128'd1 << 5) : 128'd0;
                e_ctl   = {(c >= 9 && c <= 16), (c >= 17 && c <= 24), (c <= 27) ? 2'd1 : 2'd0};
                checks++;
                if ({precb, disc} !== {e_precb, e_disc}) begin
                    errors++; $display("FAIL seq_precb_disc c=%0d got %h %h exp %h %h", c, precb, disc, e_precb, e_disc);
                end
                checks++;
                if ({wl, vpass} !== {e_wl, e_vpass}) begin
                    errors++; $display("FAIL seq_wl_vpass c=%0d got %h %h exp %h %h", c, wl, vpass, e_wl, e_vpass);
                end
                checks++;
                if ({adc1, adc2, mode} !== e_ctl) begin
                    errors++; $display("FAIL seq_adc_mode c=%0d got %b exp %b", c, {adc1, adc2, mode}, e_ctl);
                end
            end
            if (c == 4) begin
                checks++;
                if (dout !== 32'h1) begin
                    errors++; $display("FAIL seq_status_busy got %h exp 1", dout);
                end
            end
            if (c == 29) begin
                checks++;
                if (dout !== 32'h2) begin
                    errors++; $display("FAIL seq_status_done got %h exp 2", dout);
                end
            end
            addr = A_STAT;
            rd = (c == 3 || c == 28);
            tick();
        end
        rd = 1'b0;
    endtask

    task automatic test_capture();
        for (int k = 0; k < 32; k++) efl[32*k +: 32] = 32'hA5A5_0000 + 32'(k);
        wr1(A_CMD, 32'h0000_7F02);
        for (int c = 1; c <= 28; c++) begin
            checks++;
            if (vpass !== 128'd0) begin
                errors++; $display("FAIL cap_vpass c=%0d got %h exp 0", c, vpass);
            end
            if (c == 12) begin
                checks++;
                if ({wl, mode} !== {128'd1 << 127, 2'd2}) begin
                    errors++; $display("FAIL cap_wl_mode got %h %h exp row127 mode2", wl, mode);
                end
            end
            if (c == 11) begin
                checks++;
                if (dout !== 32'd0) begin
                    errors++; $display("FAIL cap_read_busy got %h exp 0", dout);
                end
            end
            addr = 32'h4000_0010;
            rd = (c == 10);
            tick();
        end
        rd = 1'b0;
        rd1(32'h4000_0010);
        checks++;
        if (dout !== 32'hA5A5_0000) begin
            errors++; $display("FAIL cap_res0 got %h exp a5a50000", dout);
        end
        rd1(32'h4000_008C);
        checks++;
        if (dout !== 32'hA5A5_001F) begin
            errors++; $display("FAIL cap_res31 got %h exp a5a5001f", dout);
        end
        tick(); tick();
        checks++;
        if (dout !== 32'hA5A5_001F) begin
            errors++; $display("FAIL cap_hold got %h exp a5a5001f", dout);
        end
        rd1(32'h4000_000C);
        checks++;
        if (dout !== 32'd0) begin
            errors++; $display("FAIL cap_unmapped got %h exp 0", dout);
        end
        rd1(32'h4000_0014);
        checks++;
        if (dout !== 32'hA5A5_0001) begin
            errors++; $display("FAIL cap_res1 got %h exp a5a50001", dout);
        end
        rd1(32'h4000_0090);
        checks++;
        if (dout !== 32'd0) begin
            errors++; $display("FAIL cap_past_end got %h exp 0", dout);
        end
    endtask

    task automatic test_errors();
        wr1(A_CMD, 32'h0000_C801);
        rd1(A_STAT);
        checks++;
        if (dout !== 32'h6) begin
            errors++; $display("FAIL err_row200 got %h exp 6", dout);
        end
        addr = A_STAT; wdata = 32'h4; wr = 1'b1; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        checks++;
        if (dout !== 32'h6) begin
            errors++; $display("FAIL err_rw_same_cycle got %h exp 6", dout);
        end
        rd1(A_STAT);
        checks++;
        if (dout !== 32'h2) begin
            errors++; $display("FAIL err_clear got %h exp 2", dout);
        end
        wr1(A_CMD, 32'h0000_0100);
        rd1(A_STAT);
        checks++;
        if ({dout, mode} !== {32'h6, 2'd0}) begin
            errors++; $display("FAIL err_mode0 got %h %h exp 6 0", dout, mode);
        end
        wr1(A_STAT, 32'h4);
        wr1(A_CMD, 32'h0000_0501);
        tick();
        wr1(A_CMD, 32'h0000_0701);
        rd1(A_STAT);
        checks++;
        if (dout !== 32'h5) begin
            errors++; $display("FAIL err_busy_status got %h exp 5", dout);
        end
        tick(); tick();
        checks++;
        if ({wl, mode} !== {128'd1 << 5, 2'd1}) begin
            errors++; $display("FAIL err_busy_unchanged got %h %h exp row5 mode1", wl, mode);
        end
        for (int i = 0; i < 40 && mode != 2'd0; i++) tick();
        checks++;
        if (mode !== 2'd0) begin
            errors++; $display("FAIL err_seq_timeout got mode %h exp 0", mode);
        end
        rd1(A_STAT);
        checks++;
        if (dout !== 32'h6) begin
            errors++; $display("FAIL err_after_busy got %h exp 6", dout);
        end
        wr1(A_STAT, 32'h4);
    endtask

    task automatic test_reset_mid();
        int cnt;
        logic saw_wl;
        wr1(A_CMD, 32'h0000_0501);
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (adc1 !== 1'b1) begin
            errors++; $display("FAIL mid_in_adc1 got %b exp 1", adc1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({precb, disc, wl, vpass} !== {{128{1'b1}}, 384'd0}) begin
            errors++; $display("FAIL mid_array_reset got %h %h %h exp reset values", precb, wl, disc);
        end
        checks++;
        if ({adc1, adc2, mode, dout} !== 36'd0) begin
            errors++; $display("FAIL mid_ctrl_reset got %b %b %h %h exp 0", adc1, adc2, mode, dout);
        end
        rd1(A_STAT);
        checks++;
        if (dout !== 32'd0) begin
            errors++; $display("FAIL mid_status got %h exp 0", dout);
        end
        rd1(32'h4000_0010);
        checks++;
        if (dout !== 32'd0) begin
            errors++; $display("FAIL mid_buf_cleared got %h exp 0", dout);
        end
        cnt = 0; saw_wl = 1'b0;
        wr1(A_CMD, 32'h0000_0301);
        for (int i = 0; i < 60; i++) begin
            if (mode != 2'd0) cnt++;
            if (wl == (128'd1 << 3)) saw_wl = 1'b1;
            tick();
        end
        checks++;
        if ({cnt, saw_wl} !== {32'd27, 1'b1}) begin
            errors++; $display("FAIL mid_rerun got len %0d wl %b exp 27 1", cnt, saw_wl);
        end
        rd1(32'h4000_0010);
        checks++;
        if (dout !== 32'hA5A5_0000) begin
            errors++; $display("FAIL mid_rerun_capture got %h exp a5a50000", dout);
        end
        rd1(A_STAT);
        checks++;
        if (dout !== 32'h2) begin
            errors++; $display("FAIL mid_rerun_status got %h exp 2", dout);
        end
    endtask

    task automatic test_params();
        int cnt, wcnt, vcnt;
        cnt = 0; wcnt = 0; vcnt = 0;
        wr_2(A_CMD, 32'h0000_0F01);
        for (int i = 0; i < 40; i++) begin
            if (mode2 != 2'd0) cnt++;
            if (wl2 == 16'h8000) wcnt++;
            if (vpass2 == 16'h7FFF) vcnt++;
            tick();
        end
        checks++;
        if (cnt !== 13) begin
            errors++; $display("FAIL p_seq_len got %0d exp 13", cnt);
        end
        checks++;
        if ({wcnt, vcnt} !== {32'd7, 32'd7}) begin
            errors++; $display("FAIL p_wl_len got %0d %0d exp 7 7", wcnt, vcnt);
        end
        rd_2(A_STAT);
        checks++;
        if (dout2 !== 32'h2) begin
            errors++; $display("FAIL p_done got %h exp 2", dout2);
        end
        wr_2(A_CMD, 32'h0000_1001);
        rd_2(A_STAT);
        checks++;
        if ({dout2, mode2} !== {32'h6, 2'd0}) begin
            errors++; $display("FAIL p_row16_err got %h %h exp 6 0", dout2, mode2);
        end
        rd_2(32'h5000_0004);
        checks++;
        if (dout2 !== 32'd0) begin
            errors++; $display("FAIL p_no_hit got %h exp 0", dout2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0; efl = '0;
        rst2 = 1'b0; wr2 = 1'b0; rd2 = 1'b0; addr2 = '0; wdata2 = '0; efl2 = '0;
        tick();
        test_reset();
        test_seq_timing();
        test_capture();
        test_errors();
        test_reset_mid();
        test_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
